// File: rtl/csi2tx_p2b_pkg.sv
// Shared constants and types for the CSI-2 TX pixel-to-byte sequencer
// and the CSI-2 packet header builder.
package csi2tx_p2b_pkg;

  localparam int DT_W = 6;

  // CSI-2 RAW data type codes
  localparam logic [DT_W-1:0] DT_RAW6  = 6'h28;
  localparam logic [DT_W-1:0] DT_RAW8  = 6'h2A;
  localparam logic [DT_W-1:0] DT_RAW10 = 6'h2B;
  localparam logic [DT_W-1:0] DT_RAW12 = 6'h2C;
  localparam logic [DT_W-1:0] DT_RAW14 = 6'h2D;

  // Last pixel index of each converter's packing group
  localparam logic [3:0] WRAP_RAW6  = 4'd15;
  localparam logic [3:0] WRAP_RAW8  = 4'd3;
  localparam logic [3:0] WRAP_RAW10 = 4'd15;
  localparam logic [3:0] WRAP_RAW12 = 4'd7;
  localparam logic [3:0] WRAP_RAW14 = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  typedef struct packed {
    logic raw14;
    logic raw12;
    logic raw10;
    logic raw8;
    logic raw6;
  } conv_en_t;

endpackage

// File: rtl/csi2tx_p2b_seq_if.sv
// Sensor-to-converter pixel bus: sensor stream in, registered stream,
// packing index, flush strobe and converter enables out.
interface csi2tx_p2b_seq_if
  import csi2tx_p2b_pkg::*;
#(
  parameter int PIX_W = 14
);
  logic [DT_W-1:0]  cfg_data_type;
  logic [PIX_W-1:0] sensor_pixel_data;
  logic             sensor_pixel_vld;
  logic [PIX_W-1:0] p2b_pixel_data;
  logic             p2b_pixel_data_vld;
  logic [3:0]       p2b_pixel_cnt;
  logic             sensor_pixel_vld_falling_edge;
  logic             raw6_convrn_enable;
  logic             raw8_convrn_enable;
  logic             raw10_convrn_enable;
  logic             raw12_convrn_enable;
  logic             raw14_convrn_enable;

  modport master (
    input  cfg_data_type, sensor_pixel_data, sensor_pixel_vld,
    output p2b_pixel_data, p2b_pixel_data_vld, p2b_pixel_cnt,
           sensor_pixel_vld_falling_edge,
           raw6_convrn_enable, raw8_convrn_enable, raw10_convrn_enable,
           raw12_convrn_enable, raw14_convrn_enable
  );

  modport slave (
    output cfg_data_type, sensor_pixel_data, sensor_pixel_vld,
    input  p2b_pixel_data, p2b_pixel_data_vld, p2b_pixel_cnt,
           sensor_pixel_vld_falling_edge,
           raw6_convrn_enable, raw8_convrn_enable, raw10_convrn_enable,
           raw12_convrn_enable, raw14_convrn_enable
  );
endinterface

// File: rtl/csi2tx_p2b_dt_decode.sv
// Maps a CSI-2 data type to a one-hot converter enable, the packing group
// wrap index and an unsupported-format flag. Purely combinational.
module csi2tx_p2b_dt_decode
  import csi2tx_p2b_pkg::*;
(
  input  logic [DT_W-1:0] dt,
  output conv_en_t        en,
  output logic [3:0]      wrap,
  output logic            unsupported
);

  // Table lookup; unknown codes enable nothing and use a 16-pixel group
  always_comb begin
    en          = '0;
    wrap        = WRAP_RAW14;
    unsupported = 1'b0;
    case (dt)
      DT_RAW6:  begin en.raw6  = 1'b1; wrap = WRAP_RAW6;  end
      DT_RAW8:  begin en.raw8  = 1'b1; wrap = WRAP_RAW8;  end
      DT_RAW10: begin en.raw10 = 1'b1; wrap = WRAP_RAW10; end
      DT_RAW12: begin en.raw12 = 1'b1; wrap = WRAP_RAW12; end
      DT_RAW14: begin en.raw14 = 1'b1; wrap = WRAP_RAW14; end
      default:  unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/csi2tx_p2b_seq.sv
// Pixel-to-byte sequencer: registers the sensor stream, selects the RAW
// converter for the line, produces the packing index and flush strobe,
// counts line pixels and flags format / gap errors.
module csi2tx_p2b_seq
  import csi2tx_p2b_pkg::*;
#(
  parameter int PIX_W  = 14,
  parameter int LCNT_W = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  csi2tx_p2b_seq_if.master  bus,
  output logic [LCNT_W-1:0] line_pix_cnt,
  output logic              line_done,
  output logic              fmt_err,
  output logic              gap_err,
  output logic              busy
);

  state_t           state, state_nxt;
  logic [DT_W-1:0]  dt_q;
  conv_en_t         dec_en, en_act;
  logic [3:0]       dec_wrap;
  logic             dec_unsup;
  logic             accept;
  logic [PIX_W-1:0] pix_p1;
  logic             vld_p1, vld_p2;
  logic [3:0]       cnt_p1;

  function automatic logic [LCNT_W-1:0] sat_inc(input logic [LCNT_W-1:0] v);
    return (&v) ? v : v + LCNT_W'(1);
  endfunction

  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] wrap);
    return (v == wrap) ? 4'd0 : v + 4'd1;
  endfunction

  csi2tx_p2b_dt_decode u_dt_decode (
    .dt          (dt_q),
    .en          (dec_en),
    .wrap        (dec_wrap),
    .unsupported (dec_unsup)
  );

  // A pixel arriving in the flush cycle is discarded
  assign accept = bus.sensor_pixel_vld && (state != FLUSH);

  // State register and data-type capture at line start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.sensor_pixel_vld) dt_q <= bus.cfg_data_type;
    end
  end

  // Next-state logic and state-qualified outputs
  always_comb begin
    state_nxt = state;
    en_act    = '0;
    busy      = 1'b0;
    line_done = 1'b0;
    fmt_err   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sensor_pixel_vld) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        busy    = 1'b1;
        en_act  = dec_en;
        fmt_err = dec_unsup && (line_pix_cnt == '0);
        if (!bus.sensor_pixel_vld) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy      = 1'b1;
        en_act    = dec_en;
        line_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: register the pixel, valid, packing index and line counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_p1       <= '0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      cnt_p1       <= '0;
      line_pix_cnt <= '0;
      gap_err      <= 1'b0;
    end else begin
      vld_p1  <= accept;
      vld_p2  <= vld_p1;
      gap_err <= (state == FLUSH) && bus.sensor_pixel_vld;
      if (accept) pix_p1 <= bus.sensor_pixel_data;
      if (state == FLUSH)  cnt_p1 <= '0;
      else if (vld_p1)     cnt_p1 <= wrap_inc(cnt_p1, dec_wrap);
      if (state == IDLE && bus.sensor_pixel_vld) line_pix_cnt <= '0;
      else if (vld_p1)                           line_pix_cnt <= sat_inc(line_pix_cnt);
    end
  end

  assign bus.p2b_pixel_data                = pix_p1;
  assign bus.p2b_pixel_data_vld            = vld_p1;
  assign bus.p2b_pixel_cnt                 = cnt_p1;
  assign bus.sensor_pixel_vld_falling_edge = vld_p2 && !vld_p1;
  assign bus.raw6_convrn_enable            = en_act.raw6;
  assign bus.raw8_convrn_enable            = en_act.raw8;
  assign bus.raw10_convrn_enable           = en_act.raw10;
  assign bus.raw12_convrn_enable           = en_act.raw12;
  assign bus.raw14_convrn_enable           = en_act.raw14;

endmodule

// File: doc/csi2tx_p2b_seq.md
Name: csi2tx_p2b_seq

Overview:
Sequencer in front of the CSI-2 TX pixel-to-byte converters (RAW6/8/10/12/14). It registers the sensor pixel stream and decodes the line's data type into a one-hot converter enable. It generates the per-format wrapping pixel count and the valid falling-edge strobe that the converters use for packing and partial-word flush. It also tracks per-line pixel count and flags protocol errors.

Parameters:
PIX_W, 14, sensor pixel width (converters consume up to 14 bits).
LCNT_W, 16, width of line pixel counter.

Ports:
clk  in  1  clock
rst_n  in  1  reset
cfg_data_type  in  6  CSI-2 data type; sampled on the first pixel of a line
sensor_pixel_data  in  PIX_W  raw sensor pixel
sensor_pixel_vld  in  1  pixel qualifier; high for the whole line, low between lines
p2b_pixel_data  out  PIX_W  registered pixel to the converters
p2b_pixel_data_vld  out  1  registered valid
p2b_pixel_cnt  out  4  pixel index within the packing group
sensor_pixel_vld_falling_edge  out  1  one-cycle strobe, first cycle after the last registered pixel
raw6_convrn_enable / raw8_ / raw10_ / raw12_ / raw14_  out  1 each  one-hot converter enables
line_pix_cnt  out  LCNT_W  pixels accepted in the current/last line
line_done  out  1  one-cycle pulse at line end
fmt_err  out  1  one-cycle pulse: unsupported data type at line start
gap_err  out  1  one-cycle pulse: valid reasserted during FLUSH
busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk.
- All outputs reset to 0. Reset mid-line abandons the line: no line_done or falling-edge strobe.
- FSM states:
  - IDLE -> ACTIVE when sensor_pixel_vld=1. On that edge, latch cfg_data_type into dt_q.
  - ACTIVE -> FLUSH when sensor_pixel_vld=0.
  - FLUSH -> IDLE unconditionally (one cycle).
- Data-type decode (from dt_q) and group wrap value:
  - 0x28 RAW6, wrap 15
  - 0x2A RAW8, wrap 3
  - 0x2B RAW10, wrap 15
  - 0x2C RAW12, wrap 7
  - 0x2D RAW14, wrap 15
  - Any other value: all enables 0, fmt_err pulses in the first registered-pixel cycle; pixels still forwarded and counted.
- Enable timing: the selected enable is high in every cycle that state is ACTIVE or FLUSH, and 0 in IDLE.
- Pipeline: p2b_pixel_data and p2b_pixel_data_vld are sensor inputs delayed by 1 cycle.
  - p2b_pixel_data holds its last value when valid is low.
- Pixel count:
  - p2b_pixel_cnt is the index of the registered pixel while p2b_pixel_data_vld=1.
  - It increments after each registered valid pixel, and goes from wrap to 0.
  - In the FLUSH cycle it holds the next index (nonzero means a partial group, which drives the converter's partial flush).
  - It clears to 0 on the FLUSH->IDLE edge.
- sensor_pixel_vld_falling_edge = registered valid delayed one cycle AND NOT registered valid. It coincides with the FLUSH cycle.
- line_pix_cnt:
  - Clears to 0 on IDLE->ACTIVE.
  - Increments per registered valid pixel and saturates at all-ones.
  - Holds its value after line end until the next line starts.
- line_done pulses in the FLUSH cycle.
- cfg_data_type changes after line start are ignored until the next IDLE->ACTIVE.
- sensor_pixel_vld=1 during FLUSH:
  - That pixel is dropped and gap_err pulses in the following cycle.
  - FSM still returns to IDLE; a valid still high in IDLE starts a new line.
- Required minimum inter-line gap: 2 low cycles.

Decomposition:
- Shared package csi2tx_p2b_pkg holds:
  - data-type constants DT_RAW6..DT_RAW14;
  - per-format wrap constants;
  - FSM state encoding (IDLE, ACTIVE, FLUSH).
- One sub-module, csi2tx_p2b_dt_decode: combinational map from dt_q to one-hot enable plus wrap value plus unsupported flag. It is reusable by the packet header builder.

Test Plan:
1. RAW14 (0x2D), 16-pixel line -> enable raw14 only; p2b_pixel_cnt 0..15; in FLUSH cnt=0 with falling edge; line_pix_cnt=16; line_done once.
2. RAW8 (0x2A), 5 pixels -> cnt sequence 0,1,2,3,0; FLUSH cnt=1 with falling edge=1; enable drops one cycle after FLUSH.
3. RAW10 (0x2B), 6 pixels, then cfg_data_type changed to 0x2C mid-line -> raw10 enable held throughout; FLUSH cnt=6; line_pix_cnt=6.
4. cfg_data_type=0x29 (RAW7), 8 pixels -> fmt_err one pulse; all enables 0; p2b data forwarded; line_pix_cnt=8.
5. RAW12, 3 pixels, valid low for 1 cycle, then 4 pixels -> gap_err pulse; first pixel of burst 2 dropped; second line line_pix_cnt=3, cnt starts at 0.
6. rst_n asserted at pixel 7 of a RAW14 line -> all outputs 0 immediately; no line_done; next line starts with cnt=0.
